// File: rtl/prim_leading_count_pipe.sv
// Two-stage pipelined CLZ/CLO/CTZ/CTO counter with valid/ready on both sides.
// Optional sideband tag channel enabled by defining PRIM_LCP_TAG_EN.
module prim_leading_count_pipe #(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
`ifdef PRIM_LCP_TAG_EN
    input  logic [TAG_W-1:0] i_tag,
    output logic [TAG_W-1:0] o_tag,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CW-1:0]    o_count,
    output logic             o_none,
    output logic [1:0]       o_mode
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (CW > 2) ? CW - 2 : 1;

    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_badWidth
        $error("prim_leading_count_pipe: WIDTH must be a power of two in 8..64");
    end
    if (TAG_W < 1) begin : g_badTag
        $error("prim_leading_count_pipe: TAG_W must be at least 1");
    end

    function automatic logic [1:0] lz2(input logic [3:0] nib);
        logic [1:0] cnt;
        casez (nib)
            4'b1???: cnt = 2'd0;
            4'b01??: cnt = 2'd1;
            4'b001?: cnt = 2'd2;
            default: cnt = 2'd3;
        endcase
        return cnt;
    endfunction

    logic                r_s1Valid;
    logic [NIB-1:0][1:0] r_s1Cnt;
    logic [NIB-1:0]      r_s1Zero;
    logic [1:0]          r_s1Mode;

    logic                r_s2Valid;
    logic [CW-1:0]       r_s2Count;
    logic                r_s2None;
    logic [1:0]          r_s2Mode;

    logic                w_s1Adv;
    logic                w_s2Adv;
    logic [WIDTH-1:0]    w_inv;
    logic [WIDTH-1:0]    w_rev;
    logic [WIDTH-1:0]    w_xform;
    logic [NIB-1:0][1:0] w_nibCnt;
    logic [NIB-1:0]      w_nibZero;
    logic [IW-1:0]       w_sel;
    logic [1:0]          w_lowCnt;
    logic                w_none;
    logic [CW-1:0]       w_count;

    assign w_s2Adv = !r_s2Valid || i_ready;
    assign w_s1Adv = !r_s1Valid || w_s2Adv;
    assign o_ready = w_s1Adv;

    // Every mode is folded onto CLZ: bit 0 of the mode inverts, bit 1 reverses.
    always_comb begin
        w_inv = i_mode[0] ? ~i_data : i_data;
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rev[i] = w_inv[WIDTH-1-i];
        end
        w_xform = i_mode[1] ? w_rev : w_inv;
    end

    // Nibble 0 is the most significant nibble of the transformed word.
    always_comb begin
        w_nibCnt  = '0;
        w_nibZero = '0;
        for (int k = 0; k < NIB; k++) begin
            w_nibCnt[k]  = lz2(w_xform[WIDTH-1-4*k -: 4]);
            w_nibZero[k] = ~|w_xform[WIDTH-1-4*k -: 4];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Cnt   <= '0;
            r_s1Zero  <= '0;
            r_s1Mode  <= '0;
        end else begin
            if (w_s1Adv) begin
                r_s1Valid <= i_valid;
            end
            if (w_s1Adv && i_valid) begin
                r_s1Cnt  <= w_nibCnt;
                r_s1Zero <= w_nibZero;
                r_s1Mode <= i_mode;
            end
        end
    end

    // Walking down from the last nibble leaves the first non-zero one selected.
    always_comb begin
        w_sel = '0;
        for (int k = NIB - 1; k >= 0; k--) begin
            if (!r_s1Zero[k]) begin
                w_sel = IW'(k);
            end
        end
        w_none   = &r_s1Zero;
        w_lowCnt = r_s1Cnt[w_sel];
        w_count  = w_none ? '0 : CW'({w_sel, w_lowCnt});
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2Valid <= 1'b0;
            r_s2Count <= '0;
            r_s2None  <= 1'b0;
            r_s2Mode  <= '0;
        end else begin
            if (w_s2Adv) begin
                r_s2Valid <= r_s1Valid;
            end
            if (w_s2Adv && r_s1Valid) begin
                r_s2Count <= w_count;
                r_s2None  <= w_none;
                r_s2Mode  <= r_s1Mode;
            end
        end
    end

`ifdef PRIM_LCP_TAG_EN
    logic [TAG_W-1:0] r_s1Tag;
    logic [TAG_W-1:0] r_s2Tag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1Tag <= '0;
            r_s2Tag <= '0;
        end else begin
            if (w_s1Adv && i_valid) begin
                r_s1Tag <= i_tag;
            end
            if (w_s2Adv && r_s1Valid) begin
                r_s2Tag <= r_s1Tag;
            end
        end
    end

    assign o_tag = r_s2Tag;
`endif

    assign o_valid = r_s2Valid;
    assign o_count = r_s2Count;
    assign o_none  = r_s2None;
    assign o_mode  = r_s2Mode;

endmodule

// File: tb/tb_prim_leading_count_pipe.sv
// Directed self-checking bench for prim_leading_count_pipe (WIDTH 32 main, plus 8 and 64).
module tb_prim_leading_count_pipe;

    typedef struct {
        logic [5:0] count;
        logic       none;
        logic [1:0] mode;
        logic [3:0] tag;
    } expBeat_t;

    logic        clk;
    logic        rstN;
    logic        iValid;
    logic        oReady;
    logic [31:0] iData;
    logic [1:0]  iMode;
    logic [3:0]  iTag;
    logic        oValid;
    logic        iReady;
    logic [4:0]  oCount;
    logic        oNone;
    logic [1:0]  oMode;
    logic [3:0]  oTag;

    logic        v8, r8, ov8, n8;
    logic [7:0]  d8;
    logic [2:0]  c8;
    logic [1:0]  m8;
    logic        v64, r64, ov64, n64;
    logic [63:0] d64;
    logic [5:0]  c64;
    logic [1:0]  m64;
    logic        rdyOne;
    logic [1:0]  modeZero;

    expBeat_t    expQ[$];
    logic [5:0]  curCount;
    logic        curNone;
    int          testCount = 0;
    int          failCount = 0;
    bit          stallDone;
    bit          sawValid;

    prim_leading_count_pipe #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_valid(iValid), .o_ready(oReady),
        .i_data(iData), .i_mode(iMode),
`ifdef PRIM_LCP_TAG_EN
        .i_tag(iTag), .o_tag(oTag),
`endif
        .o_valid(oValid), .i_ready(iReady), .o_count(oCount), .o_none(oNone), .o_mode(oMode)
    );

`ifdef PRIM_LCP_TAG_EN
    logic [3:0] tag8, tag64;
    prim_leading_count_pipe #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rstN), .i_valid(v8), .o_ready(r8), .i_data(d8), .i_mode(modeZero),
        .i_tag(4'h0), .o_tag(tag8),
        .o_valid(ov8), .i_ready(rdyOne), .o_count(c8), .o_none(n8), .o_mode(m8)
    );
    prim_leading_count_pipe #(.WIDTH(64)) dut64 (
        .i_clk(clk), .i_rst_n(rstN), .i_valid(v64), .o_ready(r64), .i_data(d64), .i_mode(modeZero),
        .i_tag(4'h0), .o_tag(tag64),
        .o_valid(ov64), .i_ready(rdyOne), .o_count(c64), .o_none(n64), .o_mode(m64)
    );
`else
    prim_leading_count_pipe #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rstN), .i_valid(v8), .o_ready(r8), .i_data(d8), .i_mode(modeZero),
        .o_valid(ov8), .i_ready(rdyOne), .o_count(c8), .o_none(n8), .o_mode(m8)
    );
    prim_leading_count_pipe #(.WIDTH(64)) dut64 (
        .i_clk(clk), .i_rst_n(rstN), .i_valid(v64), .o_ready(r64), .i_data(d64), .i_mode(modeZero),
        .o_valid(ov64), .i_ready(rdyOne), .o_count(c64), .o_none(n64), .o_mode(m64)
    );
    assign oTag = 4'h0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    // Bit-serial reference, independent of the nibble structure in the design.
    function automatic logic [6:0] refCount(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] x;
        logic [31:0] y;
        logic [5:0]  cnt;
        logic        found;
        x = m[0] ? ~d : d;
        for (int i = 0; i < 32; i++) y[i] = x[31-i];
        if (m[1]) x = y;
        cnt = 0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (x[i]) found = 1'b1;
                else cnt++;
            end
        end
        if (!found) cnt = 0;
        return {!found, cnt};
    endfunction

    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] m, input logic [3:0] t,
                                 input logic [5:0] expCount, input logic expNone);
        int waited;
        iValid   = 1'b1;
        iData    = d;
        iMode    = m;
        iTag     = t;
        curCount = expCount;
        curNone  = expNone;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!oReady && waited < 200);
        if (!oReady) checkOutput("acceptTimeout", 64'(oReady), 64'd1);
        @(posedge clk);
        #1;
        iValid = 1'b0;
    endtask

    // Scoreboard: accepts and consumes are sampled mid-cycle, ahead of the edge that performs them.
    always @(negedge clk) begin
        if (rstN) begin
            if (oValid && iReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousResult", 64'(oValid), 64'd0);
                end else begin
                    expBeat_t e;
                    e = expQ.pop_front();
                    checkOutput("count", 64'(oCount), 64'(e.count));
                    checkOutput("none", 64'(oNone), 64'(e.none));
                    checkOutput("mode", 64'(oMode), 64'(e.mode));
`ifdef PRIM_LCP_TAG_EN
                    checkOutput("tag", 64'(oTag), 64'(e.tag));
`endif
                end
            end
            if (iValid && oReady) begin
                expQ.push_back('{count: curCount, none: curNone, mode: iMode, tag: iTag});
            end
        end
    end

    initial begin
        logic [6:0]  r;
        logic [31:0] rd;
        logic [1:0]  rm;
        int          waited;
        rstN = 1'b0; iValid = 1'b0; iData = '0; iMode = '0; iTag = '0; iReady = 1'b1;
        v8 = 1'b0; d8 = '0; v64 = 1'b0; d64 = '0; rdyOne = 1'b1; modeZero = 2'b00;
        curCount = '0; curNone = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", 64'(oValid), 64'd0);
        checkOutput("rstCount", 64'(oCount), 64'd0);
        checkOutput("rstNone", 64'(oNone), 64'd0);
        checkOutput("rstMode", 64'(oMode), 64'd0);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstReady", 64'(oReady), 64'd1);

        // Latency: accepted at edge N, visible after edge N+1
        applyStimulus(32'h0001_0000, 2'b00, 4'h1, 6'd15, 1'b0);
        @(negedge clk);
        checkOutput("latencyEarly", 64'(oValid), 64'd0);
        @(negedge clk);
        checkOutput("latencyOnTime", 64'(oValid), 64'd1);

        // Back-to-back CLZ then the other modes
        applyStimulus(32'h0001_0000, 2'b00, 4'h2, 6'd15, 1'b0);
        applyStimulus(32'h8000_0000, 2'b00, 4'h3, 6'd0,  1'b0);
        applyStimulus(32'h0000_0001, 2'b00, 4'h4, 6'd31, 1'b0);
        applyStimulus(32'h0000_0000, 2'b00, 4'h5, 6'd0,  1'b1);
        applyStimulus(32'hFFF0_0000, 2'b01, 4'h6, 6'd12, 1'b0);
        applyStimulus(32'h0000_0080, 2'b10, 4'h7, 6'd7,  1'b0);
        applyStimulus(32'h0000_000F, 2'b11, 4'h8, 6'd4,  1'b0);
        applyStimulus(32'hFFFF_FFFF, 2'b11, 4'h9, 6'd0,  1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: A and B fill the pipe, C waits until the sink opens
        iReady = 1'b0;
        applyStimulus(32'h0001_0000, 2'b00, 4'hA, 6'd15, 1'b0);
        applyStimulus(32'h8000_0000, 2'b00, 4'hB, 6'd0,  1'b0);
        fork
            applyStimulus(32'h0000_0080, 2'b10, 4'hC, 6'd7, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stallReady", 64'(oReady), 64'd0);
                    checkOutput("stallCount", 64'(oCount), 64'd15);
                end
                @(posedge clk);
                #1;
                iReady = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Random CLZ/CTZ beats against the reference, with random sink stalls
        stallDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    rd = (i % 6 == 5) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
                    rm = (i % 2 == 0) ? 2'b00 : 2'b10;
                    r  = refCount(rd, rm);
                    applyStimulus(rd, rm, 4'(i + 1), r[5:0], r[6]);
                end
                stallDone = 1'b1;
            end
            begin
                while (!stallDone) begin
                    @(posedge clk);
                    #1;
                    iReady = ($urandom_range(0, 3) != 0);
                end
                iReady = 1'b1;
            end
        join
        waited = 0;
        while ((expQ.size() != 0 || oValid) && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);

        // Reset with two beats in flight
        iReady = 1'b0;
        applyStimulus(32'h0000_0001, 2'b00, 4'hD, 6'd31, 1'b0);
        applyStimulus(32'h0000_0002, 2'b00, 4'hE, 6'd30, 1'b0);
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("asyncRstValid", 64'(oValid), 64'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        rstN   = 1'b1;
        iReady = 1'b1;
        checkOutput("postRstReady", 64'(oReady), 64'd1);
        sawValid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (oValid) sawValid = 1'b1;
        end
        checkOutput("noStaleResult", 64'(sawValid), 64'd0);

        // Width 8 and 64 instances
        v8 = 1'b1; d8 = 8'h01; v64 = 1'b1; d64 = 64'h1;
        @(posedge clk);
        #1;
        v8 = 1'b0; v64 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("w8Valid", 64'(ov8), 64'd1);
        checkOutput("w8Count01", 64'(c8), 64'd7);
        checkOutput("w64Count1", 64'(c64), 64'd63);
        v8 = 1'b1; d8 = 8'h10; v64 = 1'b1; d64 = 64'h0000_0001_0000_0000;
        @(posedge clk);
        #1;
        v8 = 1'b0; v64 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("w8Count10", 64'(c8), 64'd3);
        checkOutput("w64Count32", 64'(c64), 64'd31);
        checkOutput("w64None", 64'(n64), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/prim_leading_count_pipe.md
Name: prim_leading_count_pipe

Overview:
Parametrised, pipelined bit-position counter and the successor to the 32-bit combinational leading-zero counter.
Per transaction it counts leading zeros, leading ones, trailing zeros or trailing ones of a WIDTH-bit word, selected by i_mode.
It is a two-stage registered pipeline with valid/ready handshakes on both sides.
It sits in FPU normalisation paths, the CLZ/CTZ execution unit and priority-select logic, wherever the combinational version limits timing.

Parameters:
WIDTH, 32, data width; power of two, 8..64; elaboration $error otherwise.
CW, $clog2(WIDTH), derived count width; not to be overridden.
TAG_W, 4, sideband tag width; used only when PRIM_LCP_TAG_EN is defined.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  upstream beat valid.
o_ready  output  1  block can accept a beat this cycle.
i_data  input  WIDTH  operand.
i_mode  input  2  00 CLZ, 01 CLO, 10 CTZ, 11 CTO.
i_tag  input  TAG_W  sideband tag (PRIM_LCP_TAG_EN only).
o_valid  output  1  result valid.
i_ready  input  1  downstream accepts result.
o_count  output  CW  count result.
o_none  output  1  no target bit found (operand all-zero after transform).
o_mode  output  2  mode of this result.
o_tag  output  TAG_W  tag of this result (PRIM_LCP_TAG_EN only).

Behaviour:
- Reset (async assert, synchronous release on i_clk): s1_valid=0, s2_valid=0; o_valid, o_count, o_none, o_mode, o_tag all 0.
- Transfers: a beat is accepted when i_valid && o_ready. A result is consumed when o_valid && i_ready.
- Advance rules:
  - s2_adv = !s2_valid || i_ready.
  - s1_adv = !s1_valid || s2_adv.
  - o_ready = s1_adv. This is a combinational path from i_ready and is allowed.
- Throughput and capacity: 1 beat/cycle when i_ready=1. Capacity is 2 beats. No loss, duplication or reordering.
- Latency: a beat accepted at edge N appears on o_valid after edge N+1 if not stalled, i.e. 2 registered stages.
- Stage 1, on accept:
  - Transform the operand: CLO inverts; CTZ bit-reverses; CTO inverts and bit-reverses. The problem then reduces to CLZ.
  - Split the transformed word into WIDTH/4 nibbles. Per nibble, compute a 2-bit leading-zero count and an all-zero flag.
  - Register the nibble counts, all-zero flags, mode and tag into s1.
- Stage 2:
  - Priority-encode the first non-zero nibble, MSB-first, into the upper CW-2 count bits.
  - Mux that nibble's 2-bit count into the low 2 bits.
  - o_none = AND of all nibble flags. When o_none=1, o_count is forced to 0.
  - Register into s2, which drives the outputs directly.
- Stall: while o_valid && !i_ready, o_count, o_none, o_mode and o_tag hold stable. s1 holds if s1_valid. An s1 bubble may still fill from upstream.
- Simultaneous events: consume and accept in the same cycle with both stages full is legal. s1 moves to s2 and the new beat enters s1.
- Mode and tag are captured per beat; they may change every cycle.
- Reset mid-operation flushes both stages immediately. In-flight beats are discarded, and o_valid drops asynchronously.
- Outputs are 0 while o_valid=0 only after reset. Otherwise they retain the last result (no-care).

Optional Feature:
PRIM_LCP_TAG_EN:
- Defined: i_tag/o_tag ports exist. The tag is carried through both stages with its beat and held during stalls. Reset value is 0.
- Undefined: no tag ports and no tag flops. TAG_W is ignored. All other behaviour is identical.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream with 2 beats in flight -> o_valid=0 immediately; after release, o_ready=1 and no stale result emerges.
- CLZ, WIDTH=32, back-to-back with i_ready=1, results at 2-cycle latency, one per cycle:
  - 0x0001_0000 -> count 15, none 0.
  - 0x8000_0000 -> 0.
  - 0x0000_0001 -> 31.
  - 0x0 -> count 0, none 1.
- Modes, WIDTH=32:
  - CLO 0xFFF0_0000 -> 12.
  - CTZ 0x0000_0080 -> 7.
  - CTO 0x0000_000F -> 4.
  - CTO 0xFFFF_FFFF -> count 0, none 1.
  - o_mode matches each beat's mode.
- Backpressure: i_ready=0 with beats A,B,C offered -> A and B accepted, o_ready=0 while C waits, o_count stable. On i_ready=1, the order is A,B,C with no loss or duplication.
- Width sweep: WIDTH=8: 0x01 -> 7; 0x10 -> 3. WIDTH=64: 0x1 -> 63; 0x0000_0001_0000_0000 -> 31. Random CLZ/CTZ checks against a reference model; WIDTH=12 must fail elaboration.
- PRIM_LCP_TAG_EN defined: tags 1,2,3 with random i_ready stalls -> o_tag equals the tag of the matching beat on every consumed result.
